// File: rtl/online_result_converter.sv
// MSDF radix-2 signed-digit to two's-complement converter for the online multiplier's result stream.
// Q/QM on-the-fly conversion: leading SKIP digits are dropped, the next N digits form the result.
module online_result_converter #(
    parameter int N    = 8,
    parameter int SKIP = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         digit_valid,
    input  logic [1:0]   digit,
    output logic         busy,
    output logic [N:0]   result,
    output logic         result_valid,
    output logic         digit_err
);

    localparam int MAXC = (N > SKIP) ? N : SKIP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SKIP_LAST = (SKIP > 0) ? CW'(SKIP - 1) : '0;
    localparam logic [CW-1:0] CONV_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_CONV,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    q_q, q_d;
    logic [N:0]    qm_q, qm_d;
    logic          err_q, err_d;
    logic [N:0]    result_q, result_d;
    logic          derr_q, derr_d;

    logic [N:0]    q_nxt, qm_nxt;
    logic          err_nxt;

    // One conversion step; an illegal 11 digit is treated as zero but flagged.
    always_comb begin
        q_nxt   = {q_q[N-1:0], 1'b0};
        qm_nxt  = {qm_q[N-1:0], 1'b1};
        err_nxt = err_q;
        case (digit)
            2'b10: begin
                q_nxt  = {q_q[N-1:0], 1'b1};
                qm_nxt = {q_q[N-1:0], 1'b0};
            end
            2'b01: begin
                q_nxt  = {qm_q[N-1:0], 1'b1};
                qm_nxt = {qm_q[N-1:0], 1'b0};
            end
            2'b11:   err_nxt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        qm_d     = qm_q;
        err_d    = err_q;
        result_d = result_q;
        derr_d   = derr_q;

        if (start) begin
            // start wins over any same-cycle digit, in every state
            state_d = (SKIP == 0) ? S_CONV : S_SKIP;
            cnt_d   = '0;
            q_d     = '0;
            qm_d    = '1;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_SKIP: begin
                    if (digit_valid) begin
                        if (cnt_q == SKIP_LAST) begin
                            state_d = S_CONV;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_CONV: begin
                    if (digit_valid) begin
                        q_d   = q_nxt;
                        qm_d  = qm_nxt;
                        err_d = err_nxt;
                        if (cnt_q == CONV_LAST) begin
                            state_d  = S_DONE;
                            result_d = q_nxt;
                            derr_d   = err_nxt;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            q_q      <= '0;
            qm_q     <= '1;
            err_q    <= 1'b0;
            result_q <= '0;
            derr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            qm_q     <= qm_d;
            err_q    <= err_d;
            result_q <= result_d;
            derr_q   <= derr_d;
        end
    end

    assign busy         = (state_q == S_SKIP) || (state_q == S_CONV);
    assign result_valid = (state_q == S_DONE);
    assign result       = result_q;
    assign digit_err    = derr_q;

endmodule

// File: tb/tb_online_result_converter.sv
// Directed bench for online_result_converter: one instance with SKIP=0, one with SKIP=3.
// Digit patterns are packed MSB-first, two bits per digit (10=+1, 01=-1, 00=0, 11=illegal).
`timescale 1ns/1ps
module tb_online_result_converter;

    logic       clk = 1'b0;
    logic       rst;
    logic       st0, dv0, st3, dv3;
    logic [1:0] dg0, dg3;
    logic       busy0, rv0, err0, busy3, rv3, err3;
    logic [8:0] res0, res3;

    int n_cmp = 0;
    int n_err = 0;
    int pulses0 = 0;
    int pulses3 = 0;
    int p_before;

    always #5 clk = ~clk;

    online_result_converter #(.N(8), .SKIP(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(st0), .digit_valid(dv0), .digit(dg0),
        .busy(busy0), .result(res0), .result_valid(rv0), .digit_err(err0)
    );

    online_result_converter #(.N(8), .SKIP(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(st3), .digit_valid(dv3), .digit(dg3),
        .busy(busy3), .result(res3), .result_valid(rv3), .digit_err(err3)
    );

    always @(negedge clk) begin
        if (rv0) pulses0++;
        if (rv3) pulses3++;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic st, input logic dv, input logic [1:0] dg);
        if (sel) begin
            st3 = st; dv3 = dv; dg3 = dg;
        end else begin
            st0 = st; dv0 = dv; dg0 = dg;
        end
    endtask

    function automatic logic busy_of(input bit sel);
        return sel ? busy3 : busy0;
    endfunction

    task automatic start_frame(input bit sel);
        drive(sel, 1'b1, 1'b0, 2'b00);
        step();
        drive(sel, 1'b0, 1'b0, 2'b00);
        check_eq("busy_after_start", 16'(busy_of(sel)), 16'd1);
    endtask

    // Sends nd digits; busy must stay high except after the frame's last digit.
    task automatic send(input bit sel, input logic [15:0] pat, input int nd,
                        input bit stall, input bit last);
        for (int i = 0; i < nd; i++) begin
            drive(sel, 1'b0, 1'b1, pat[15-2*i -: 2]);
            step();
            if (!(last && i == nd - 1))
                check_eq("busy_in_frame", 16'(busy_of(sel)), 16'd1);
            if (stall && !(last && i == nd - 1)) begin
                drive(sel, 1'b0, 1'b0, 2'b10);
                step();
                check_eq("busy_in_gap", 16'(busy_of(sel)), 16'd1);
            end
        end
        drive(sel, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic frame0(input string tag, input logic [15:0] pat,
                          input logic [8:0] exp_res, input logic exp_err);
        start_frame(1'b0);
        send(1'b0, pat, 8, 1'b0, 1'b1);
        check_eq({tag, "_valid"}, 16'(rv0), 16'd1);
        check_eq({tag, "_result"}, 16'(res0), 16'(exp_res));
        check_eq({tag, "_err"}, 16'(err0), 16'(exp_err));
        check_eq({tag, "_busy_done"}, 16'(busy0), 16'd0);
        step();
        check_eq({tag, "_valid_drop"}, 16'(rv0), 16'd0);
        check_eq({tag, "_result_hold"}, 16'(res0), 16'(exp_res));
        $display("frame %s: result=%0h err=%0b", tag, res0, err0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        step();
        step();
        check_eq("rst_busy", 16'(busy0), 16'd0);
        check_eq("rst_result", 16'(res0), 16'd0);
        check_eq("rst_valid", 16'(rv0), 16'd0);
        check_eq("rst_err", 16'(err0), 16'd0);
        check_eq("rst_busy3", 16'(busy3), 16'd0);
        rst = 1'b0;
        step();

        frame0("basic65", 16'h9002, 9'h041, 1'b0);
        frame0("allminus", 16'h5555, 9'h101, 1'b0);
        frame0("neg64", 16'h6000, 9'h1C0, 1'b0);
        frame0("illegal", 16'h9302, 9'h041, 1'b1);
        frame0("clean", 16'h9002, 9'h041, 1'b0);

        // SKIP=3 with an illegal skipped digit and digit_valid toggling
        p_before = pulses3;
        start_frame(1'b1);
        send(1'b1, 16'hE400, 3, 1'b1, 1'b0);
        send(1'b1, 16'h9002, 8, 1'b1, 1'b1);
        check_eq("skip_valid", 16'(rv3), 16'd1);
        check_eq("skip_result", 16'(res3), 16'h041);
        check_eq("skip_err", 16'(err3), 16'd0);
        check_eq("skip_busy_done", 16'(busy3), 16'd0);
        step();
        check_eq("skip_pulses", 16'(pulses3 - p_before), 16'd1);
        $display("frame skip3: result=%0h err=%0b", res3, err3);

        // Restart mid-frame: only the second frame completes
        p_before = pulses0;
        start_frame(1'b0);
        send(1'b0, 16'hAAAA, 5, 1'b0, 1'b0);
        start_frame(1'b0);
        send(1'b0, 16'hAAAA, 8, 1'b0, 1'b1);
        check_eq("restart_valid", 16'(rv0), 16'd1);
        check_eq("restart_result", 16'(res0), 16'h0FF);
        step();
        check_eq("restart_pulses", 16'(pulses0 - p_before), 16'd1);
        $display("frame restart: result=%0h", res0);

        // start during DONE: pulse still happens and the new frame begins
        p_before = pulses0;
        start_frame(1'b0);
        send(1'b0, 16'h9002, 8, 1'b0, 1'b1);
        check_eq("done_start_valid", 16'(rv0), 16'd1);
        check_eq("done_start_result", 16'(res0), 16'h041);
        start_frame(1'b0);
        check_eq("done_start_valid_drop", 16'(rv0), 16'd0);
        send(1'b0, 16'h5555, 8, 1'b0, 1'b1);
        check_eq("b2b_valid", 16'(rv0), 16'd1);
        check_eq("b2b_result", 16'(res0), 16'h101);
        step();
        check_eq("b2b_pulses", 16'(pulses0 - p_before), 16'd2);
        $display("frame back-to-back: result=%0h", res0);

        // Reset mid-frame, then digits without start are ignored
        p_before = pulses0;
        start_frame(1'b0);
        send(1'b0, 16'hAAAA, 4, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_busy", 16'(busy0), 16'd0);
        check_eq("midrst_result", 16'(res0), 16'd0);
        check_eq("midrst_valid", 16'(rv0), 16'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'b10);
            step();
            check_eq("ignored_busy", 16'(busy0), 16'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        step();
        check_eq("ignored_pulses", 16'(pulses0 - p_before), 16'd0);
        check_eq("ignored_result", 16'(res0), 16'd0);
        $display("frame midreset: result=%0h busy=%0b", res0, busy0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/online_result_converter.md
# online_result_converter

Receiving end of the online multiplier's result stream. Collects the MSDF radix-2 signed-digit product digits, one per accepted cycle, and converts them on the fly into an (N+1)-bit two's-complement integer. The first SKIP digits after `start` are discarded to absorb the multiplier's online delay. The finished word is presented with a one-cycle valid pulse for the downstream conventional-binary datapath.

## Interface
Parameters:
- N, 8, number of result digits converted per frame (N ≥ 2)
- SKIP, 3, number of leading digits discarded after `start` (0 allowed)

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  frame start pulse; also restarts an in-progress frame
- digit_valid  input  1  `digit` is valid this cycle
- digit  input  2  signed digit in plus/minus form: [1]=plus, [0]=minus; 10=+1, 01=−1, 00=0; 11 is illegal
- busy  output  1  frame in progress (states SKIP or CONVERT)
- result  output  N+1  two's-complement value Σ d_i·2^(N−i), i=1..N
- result_valid  output  1  one-cycle pulse when `result` updates
- digit_err  output  1  illegal digit (11) accepted in the completed frame; valid alongside `result`

## Operation
- The FSM has four states: IDLE, SKIP, CONVERT, DONE.
- An accepted digit is one sampled at a rising edge with `digit_valid`=1 while in SKIP or CONVERT. Digits in IDLE/DONE are ignored.
- IDLE, `start`=1 → SKIP (or CONVERT if SKIP=0). This clears the digit counter, sets Q=0, sets QM=all ones (−1), and clears the internal error flag.
- SKIP: each accepted digit increments the counter. After SKIP accepted digits, go to CONVERT with the counter cleared. Skipped digits are never checked for legality.
- CONVERT: each accepted digit updates Q/QM (N+1 bits, shift left, MSB dropped):
  - d=+1: Q←(Q<<1)|1, QM←(Q<<1)
  - d=0: Q←(Q<<1), QM←(QM<<1)|1
  - d=−1: Q←(QM<<1)|1, QM←(QM<<1)
  - 11: treated as d=0, and the internal error flag is set.
- Invariant: QM = Q−1 at all times. No overflow is possible, since |Σ| ≤ 2^N−1.
- After the Nth accepted CONVERT digit → DONE. On that same edge, `result`←next Q and `digit_err`←flag, including the current digit's legality.
- DONE lasts one cycle: `result_valid`=1, then → IDLE.
- `result` and `digit_err` hold until the next completed frame.
- `start` in SKIP/CONVERT/DONE restarts: re-initialisation as from IDLE, and the partial frame is discarded with no `result_valid`. `start` has priority over a same-cycle digit.
- `rst`=1 → IDLE. The counter, Q, `result`, `digit_err` and the flag are cleared; QM is set to all ones. Reset takes priority over `start`.
- Counter width is ceil(log2(max(N,SKIP)+1)) bits.

## Timing
- Reset values: `busy`=0, `result`=0, `result_valid`=0, `digit_err`=0.
- `busy`=1 from the cycle after the `start` edge until the edge that enters DONE; it is 0 in DONE.
- Latency: the Nth digit is accepted at edge k; `result`/`digit_err` are valid and `result_valid`=1 during cycle k+1.
- Minimum frame length is 1 + SKIP + N + 1 cycles. `digit_valid` gaps stretch the frame without penalty.
- A `start` in the DONE cycle is accepted; `result_valid` still pulses in that cycle.
- Back-to-back frames therefore need no idle cycle.

## Test plan
- Basic conversion, N=8, SKIP=0: start, then digits +1,−1,0,0,0,0,0,+1 on consecutive cycles → `result`=9'h041 (65) with one `result_valid` pulse, 1 cycle after the last digit.
- All-minus and negative values: eight −1 digits → 9'h101 (−255). Digits −1,+1,0,0,0,0,0,0 → 9'h1C0 (−64). `digit_err`=0 in both.
- Skip and stalls, SKIP=3: three arbitrary digits (including 11), then the 65 pattern with `digit_valid` toggling 1,0,1,0… → `result`=9'h041, `digit_err`=0, `busy` covers the whole stretched frame.
- Illegal digit: the 65 pattern with the 4th convert digit = 11 → `result`=9'h041, `digit_err`=1. The next clean frame → `digit_err`=0.
- Restart: `start` after 5 digits, then a full frame of eight +1 digits → a single `result_valid` pulse, `result`=9'h0FF (255). `start` during DONE → both the pulse and the new frame occur.
- Reset mid-frame: `rst` after 4 digits → next cycle `busy`=0 and `result`=0, and no `result_valid`. Subsequent digits without `start` are ignored.
